// File: rtl/dvp_tx_if.sv
// rtl/dvp_tx_if.sv - RGB565 pixel stream handshake into the DVP source
interface dvp_tx_if;
  logic        PixelValid;
  logic [15:0] PixelData;
  logic        PixelReady;

  modport master (output PixelValid, output PixelData, input PixelReady);
  modport slave  (input PixelValid, input PixelData, output PixelReady);
endinterface

// File: rtl/dvp_tx.sv
// rtl/dvp_tx.sv - OV5640-style DVP source serializing RGB565 pixels, high byte first
module dvp_tx #(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 64,
  parameter int V_ACTIVE = 720,
  parameter int VS_PULSE = 32,
  parameter int V_BACK   = 64,
  parameter int V_FRONT  = 64
) (
  input  logic        PCLK,
  input  logic        Rst_n,
  input  logic        Enable,
  dvp_tx_if.slave     pix,
  output logic        Vsync,
  output logic        Href,
  output logic [7:0]  Data,
  output logic [11:0] LineCnt,
  output logic        FrameDone,
  output logic        Underflow
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CMAX = max2(max2(2 * H_ACTIVE, H_BLANK), max2(max2(VS_PULSE, V_BACK), V_FRONT));
  localparam int CW   = $clog2(CMAX + 1);
  localparam int LW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] line;
  logic          phase;     // 0: high byte on Data, 1: low byte on Data
  logic [7:0]    low_byte;
  logic          cnt_zero;
  logic          last_line;
  logic          take;

  // Saturate the internal line index into the 12-bit visible counter.
  function automatic logic [11:0] sat12(input logic [LW-1:0] v);
    if (LW > 12 && 32'(v) > 4095) return 12'hFFF;
    return 12'(v);
  endfunction

  assign cnt_zero  = (cnt == '0);
  assign last_line = (line == LW'(V_ACTIVE - 1));

  // Ready in every cycle whose successor shows a fresh high byte.
  always_comb begin
    take = 1'b0;
    case (state)
      S_VBACK:  take = cnt_zero;
      S_HBLANK: take = cnt_zero && !last_line;
      S_ACTIVE: take = phase && !cnt_zero;
      default:  take = 1'b0;
    endcase
  end

  assign pix.PixelReady = take;

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      line      <= '0;
      phase     <= 1'b0;
      low_byte  <= 8'h00;
      Vsync     <= 1'b0;
      Href      <= 1'b0;
      Data      <= 8'h00;
      LineCnt   <= 12'h000;
      FrameDone <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      FrameDone <= 1'b0;

      if (take) begin
        Href     <= 1'b1;
        phase    <= 1'b0;
        Data     <= pix.PixelValid ? pix.PixelData[15:8] : 8'h00;
        low_byte <= pix.PixelValid ? pix.PixelData[7:0]  : 8'h00;
        if (!pix.PixelValid) Underflow <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (Enable) begin
            state <= S_VSYNC;
            Vsync <= 1'b1;
            cnt   <= CW'(VS_PULSE - 1);
          end
        end

        S_VSYNC: begin
          if (cnt_zero) begin
            state <= S_VBACK;
            Vsync <= 1'b0;
            cnt   <= CW'(V_BACK - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_VBACK: begin
          if (cnt_zero) begin
            state   <= S_ACTIVE;
            cnt     <= CW'(2 * H_ACTIVE - 1);
            line    <= '0;
            LineCnt <= 12'h000;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_ACTIVE: begin
          if (cnt_zero) begin
            state <= S_HBLANK;
            Href  <= 1'b0;
            Data  <= 8'h00;
            cnt   <= CW'(H_BLANK - 1);
          end else begin
            cnt <= cnt - 1'b1;
            if (!phase) begin
              Data  <= low_byte;
              phase <= 1'b1;
            end
          end
        end

        S_HBLANK: begin
          if (cnt_zero) begin
            if (last_line) begin
              state     <= S_VFRONT;
              cnt       <= CW'(V_FRONT - 1);
              FrameDone <= (V_FRONT == 1);
            end else begin
              state   <= S_ACTIVE;
              cnt     <= CW'(2 * H_ACTIVE - 1);
              line    <= line + 1'b1;
              LineCnt <= sat12(line + 1'b1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_VFRONT: begin
          if (cnt_zero) begin
            if (Enable) begin
              state <= S_VSYNC;
              Vsync <= 1'b1;
              cnt   <= CW'(VS_PULSE - 1);
            end else begin
              state   <= S_IDLE;
              line    <= '0;
              LineCnt <= 12'h000;
            end
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) FrameDone <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dvp_tx.sv
// tb/tb_dvp_tx.sv - directed bench for dvp_tx with frame-timing model and byte scoreboard
module tb_dvp_tx;
  localparam int H  = 4;
  localparam int HB = 3;
  localparam int V  = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VF = 2;
  localparam int LS    = VS + VB;
  localparam int LP    = 2 * H + HB;
  localparam int FRAME = LS + V * LP + VF;

  logic        PCLK;
  logic        Rst_n;
  logic        Enable;
  logic        Vsync;
  logic        Href;
  logic [7:0]  Data;
  logic [11:0] LineCnt;
  logic        FrameDone;
  logic        Underflow;

  dvp_tx_if pif ();

  dvp_tx #(
    .H_ACTIVE(H), .H_BLANK(HB), .V_ACTIVE(V),
    .VS_PULSE(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .PCLK(PCLK), .Rst_n(Rst_n), .Enable(Enable), .pix(pif.slave),
    .Vsync(Vsync), .Href(Href), .Data(Data), .LineCnt(LineCnt),
    .FrameDone(FrameDone), .Underflow(Underflow)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;

  bit   running;
  int   pos;
  int   lc;
  bit   uf;
  int   hs_cnt;
  int   slot;
  int   drop_slot;
  logic [7:0] exp_q[$];

  function automatic logic [15:0] pixel(input int s);
    logic [7:0] hi;
    hi = 8'hA1 + 8'(8'h22 * s);
    return {hi, hi + 8'h11};
  endfunction

  function automatic bit in_href(input int p);
    return (p >= LS) && (p < LS + V * LP) && (((p - LS) % LP) < 2 * H);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pixel();
    pif.PixelValid = (slot != drop_slot);
    pif.PixelData  = pixel(slot);
  endtask

  task automatic tick();
    bit rn;
    int pn;
    bit rdy_e;
    bit hs;
    logic [15:0] px;
    @(negedge PCLK);
    check("vsync", 32'(Vsync), 32'(running && pos < VS));
    check("href", 32'(Href), 32'(running && in_href(pos)));
    check("framedone", 32'(FrameDone), 32'(running && pos == FRAME - 1));
    check("linecnt", 32'(LineCnt), 32'(lc));
    check("underflow", 32'(Underflow), 32'(uf));
    if (Href) begin
      if (exp_q.size() > 0) check("data", 32'(Data), 32'(exp_q.pop_front()));
      else check("sb_depth", 32'(exp_q.size()), 32'd1);
    end else begin
      check("data_idle", 32'(Data), 32'h0);
    end
    if (running && pos == FRAME - 1) begin
      check("hs_per_frame", 32'(hs_cnt), 32'(H * V));
      check("sb_drain", 32'(exp_q.size()), 32'd0);
    end

    pn = 0;
    if (!Rst_n) rn = 1'b0;
    else if (!running || pos == FRAME - 1) rn = Enable;
    else begin
      rn = 1'b1;
      pn = pos + 1;
    end
    rdy_e = rn && in_href(pn) && ((((pn - LS) % LP) % 2) == 0);
    check("ready", 32'(pif.PixelReady), 32'(rdy_e));
    hs = pif.PixelReady;
    px = pif.PixelValid ? pif.PixelData : 16'h0000;
    if (hs) begin
      exp_q.push_back(px[15:8]);
      exp_q.push_back(px[7:0]);
    end
    @(posedge PCLK);
    #1;
    if (rn && pn == 0) hs_cnt = 0;
    if (hs) begin
      if (!pif.PixelValid) uf = 1'b1;
      hs_cnt++;
      slot++;
    end
    if (!rn) lc = 0;
    else if (pn >= LS && pn < LS + V * LP && ((pn - LS) % LP) == 0) lc = (pn - LS) / LP;
    running = rn;
    pos = pn;
    drive_pixel();
  endtask

  task automatic async_reset();
    #1 Rst_n = 1'b0;
    #1;
    check("rst_href", 32'(Href), 32'h0);
    check("rst_data", 32'(Data), 32'h0);
    check("rst_vsync", 32'(Vsync), 32'h0);
    running = 1'b0;
    pos = 0;
    lc = 0;
    uf = 1'b0;
    hs_cnt = 0;
    exp_q.delete();
  endtask

  initial begin
    Rst_n = 1'b0;
    Enable = 1'b0;
    running = 1'b0;
    pos = 0;
    lc = 0;
    uf = 1'b0;
    hs_cnt = 0;
    slot = 0;
    drop_slot = H * 1 + 2 + H * V - H;  // third pixel of line 0, second frame
    drive_pixel();

    repeat (2) tick();
    Rst_n = 1'b1;
    Enable = 1'b1;
    repeat (1 + 3 * FRAME) tick();
    repeat (20) tick();
    Enable = 1'b0;
    repeat (30) tick();
    Enable = 1'b1;
    repeat (10) tick();
    async_reset();
    repeat (2) tick();
    Rst_n = 1'b1;
    repeat (FRAME + 4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dvp_tx.md
Name: dvp_tx

Overview:
- DVP source that drives an OV5640-style parallel bus (PCLK-synchronous Vsync, Href and 8-bit Data) from a 16-bit RGB565 pixel stream.
- Pixels are accepted over a valid/ready handshake and serialized high byte first, two PCLK cycles per pixel.
- Frame timing comes from parameters.
- Used as a camera emulator to loop back into the capture path and as the sensor model in simulation.

Parameters:
H_ACTIVE  1280  pixels per line (Href high for 2*H_ACTIVE cycles)
H_BLANK   64    PCLK cycles Href low after every active line
V_ACTIVE  720   active lines per frame
VS_PULSE  32    PCLK cycles Vsync high at frame start
V_BACK    64    PCLK cycles idle between Vsync fall and first line
V_FRONT   64    PCLK cycles idle after last line's blank, before next Vsync

Ports:
PCLK        in   1   pixel clock, all logic on rising edge
Rst_n       in   1   asynchronous active-low reset
Enable      in   1   start or continue frame generation
PixelValid  in   1   PixelData holds a valid pixel
PixelData   in   16  RGB565 pixel, [15:8] sent first
PixelReady  out  1   combinational; pixel consumed on this edge when PixelValid=1
Vsync       out  1   registered, active-high frame sync
Href        out  1   registered, active-high line valid
Data        out  8   registered DVP byte
LineCnt     out  12  registered, index of line currently or last output, 0-based
FrameDone   out  1   registered 1-cycle pulse at end of V_FRONT
Underflow   out  1   sticky; set when a pixel was needed and PixelValid=0

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - State goes to IDLE.
  - Vsync, Href, Data, LineCnt, FrameDone, Underflow, byte phase and all counters go to 0.
  - PixelReady=0.
  - Reset mid-frame aborts immediately; there is no partial-line completion.
- States: IDLE -> VSYNC -> VBACK -> ACTIVE <-> HBLANK -> VFRONT -> (VSYNC if Enable else IDLE). A single cycle counter is reloaded on each transition.
- IDLE:
  - All outputs 0.
  - Enable=1 sampled at an edge enters VSYNC; Vsync=1 from that edge.
- VSYNC: Vsync=1 for exactly VS_PULSE cycles, then VBACK.
- VBACK: all low for V_BACK cycles, then ACTIVE with LineCnt=0.
- ACTIVE: Href=1 for exactly 2*H_ACTIVE cycles; byte phase alternates H,L starting with H.
- Pixel consumption:
  - PixelReady=1 in the cycle before each high byte appears on Data, i.e. the cycle whose next state is ACTIVE phase H.
  - On that edge, if PixelValid=1: Data<=PixelData[15:8], the low byte is latched internally, and on the next edge Data<=latched low byte.
  - If PixelValid=0 on a ready edge: both bytes of that pixel go out as 8'h00 and Underflow<=1. Timing never stalls.
- Data=8'h00 whenever Href=0. Href and the first high byte assert on the same edge, so output latency from the pixel handshake to its high byte is 1 cycle.
- HBLANK:
  - Href=0 for H_BLANK cycles after every line, including the last.
  - After the blank: LineCnt+1 and back to ACTIVE if lines remain; otherwise VFRONT.
  - LineCnt increments on the edge that leaves HBLANK into ACTIVE and holds at V_ACTIVE-1 through VFRONT.
- VFRONT:
  - V_FRONT idle cycles.
  - FrameDone=1 on the final VFRONT cycle only.
  - Enable is sampled on that same edge: 1 continues with VSYNC with no gap; 0 goes to IDLE and LineCnt<=0.
- Enable deasserted mid-frame: the current frame completes unchanged and the block stops at the VFRONT exit.
- Frame period: VS_PULSE+V_BACK+V_ACTIVE*(2*H_ACTIVE+H_BLANK)+V_FRONT cycles.
- Underflow clears only on reset.
- All parameters are >=1. Counters are wide enough for the default values, and LineCnt saturates its width at 12 bits.

Test Plan:
- Use H_ACTIVE=4, H_BLANK=3, V_ACTIVE=2, VS_PULSE=2, V_BACK=2, V_FRONT=2 throughout (frame = 28 cycles).
- Basic frame: Enable=1, PixelValid=1, PixelData=16'hA1B2,16'hC3D4,... -> Vsync high 2 cycles; Href high 8 cycles twice, separated by 3 low cycles; Data=A1,B2,C3,D4,...; exactly 8 PixelReady handshakes; FrameDone pulses once at cycle 28.
- Continuous frames: hold Enable=1 for 3 frames -> Vsync rises every 28 cycles; LineCnt sequence 0,1 per frame; no idle gap between FrameDone and next Vsync.
- Underflow: drop PixelValid for the 3rd pixel of line 0 -> Data=00,00 at bytes 5-6; Href timing unchanged; Underflow=1 and stays 1 through later frames.
- Stop: drop Enable during line 1 -> frame completes, FrameDone pulses, state IDLE, Vsync stays 0, LineCnt=0.
- Async reset: assert Rst_n=0 mid-ACTIVE, between edges -> Href, Data and Vsync go 0 immediately; after release with Enable=1 a fresh full frame starts.
- Loopback: connect to the capture block with matching frame size -> captured DataPixel sequence equals the injected pixels, Xaddr reaches 4 per line.
